duty_optimizer: RTL and testbench

DUTY_OPTIMIZER -- requirements
Module: duty_optimizer

---
 rtl/duty_optimizer_pkg.sv | 19 +
 rtl/duty_optimizer_clamp.sv | 44 ++++
 rtl/duty_optimizer.sv | 145 ++++++++++++++
 tb/tb_duty_optimizer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/duty_optimizer_pkg.sv
// Shared widths, duty defaults and FSM state type for the duty-cycle optimiser.
package duty_optimizer_pkg;
  localparam int DUTY_W = 12;
  localparam int CURR_W = 12;

  localparam int L_INIT_DEF = 200;
  localparam int L_MIN_DEF  = 20;
  localparam int L_MAX_DEF  = 400;
  localparam int L_STEP_DEF = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_MEAS,
    ST_EVAL,
    ST_STEP,
    ST_HOLD
  } state_t;
endpackage

// File: rtl/duty_optimizer_clamp.sv
// One saturated L_STEP move of the duty word; hit_bound flags landing on a limit.
module duty_clamp
  import duty_optimizer_pkg::*;
#(
  parameter int L_MIN  = L_MIN_DEF,
  parameter int L_MAX  = L_MAX_DEF,
  parameter int L_STEP = L_STEP_DEF
) (
  input  logic [DUTY_W-1:0] l_in,
  input  logic              up,
  output logic [DUTY_W-1:0] l_out,
  output logic              hit_bound
);
  localparam logic [DUTY_W:0] STEP_X = (DUTY_W + 1)'(L_STEP);
  localparam logic [DUTY_W:0] MIN_X  = (DUTY_W + 1)'(L_MIN);
  localparam logic [DUTY_W:0] MAX_X  = (DUTY_W + 1)'(L_MAX);

  logic [DUTY_W:0] l_ext, up_sum, dn_diff;

  // One extra bit keeps the sum from wrapping; the down path is guarded before subtracting.
  assign l_ext   = {1'b0, l_in};
  assign up_sum  = l_ext + STEP_X;
  assign dn_diff = l_ext - STEP_X;

  always_comb begin
    l_out     = l_in;
    hit_bound = 1'b0;
    if (up) begin
      if (up_sum >= MAX_X) begin
        l_out     = MAX_X[DUTY_W-1:0];
        hit_bound = 1'b1;
      end else begin
        l_out = up_sum[DUTY_W-1:0];
      end
    end else begin
      if (l_ext <= MIN_X + STEP_X) begin
        l_out     = MIN_X[DUTY_W-1:0];
        hit_bound = 1'b1;
      end else begin
        l_out = dn_diff[DUTY_W-1:0];
      end
    end
  end
endmodule

// File: rtl/duty_optimizer.sv
// Hill-climbing duty optimiser: perturb l, settle, measure mean current, keep direction
// while current rises, and park on the best duty after REV_LIMIT consecutive reversals.
module duty_optimizer
  import duty_optimizer_pkg::*;
#(
  parameter int L_INIT     = L_INIT_DEF,
  parameter int L_MIN      = L_MIN_DEF,
  parameter int L_MAX      = L_MAX_DEF,
  parameter int L_STEP     = L_STEP_DEF,
  parameter int SETTLE_CYC = 1000,
  parameter int REV_LIMIT  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              swipt_alive,
  input  logic              start,
  input  logic [CURR_W-1:0] mean_curr,
  input  logic              mean_valid,
  input  logic              l_rdy,
  input  logic              l_up_down,
  output logic [DUTY_W-1:0] l,
  output logic              measure,
  output logic              busy,
  output logic              done
);
  localparam int CNT_W = $clog2(SETTLE_CYC + 1);
  localparam int REV_W = $clog2(REV_LIMIT + 2);
  localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [REV_W-1:0]  REV_MAX     = REV_W'(REV_LIMIT);
  localparam logic [DUTY_W-1:0] L_RESET     = DUTY_W'(L_INIT);

  state_t state, state_next;
  logic [CNT_W-1:0]  settle_cnt;
  logic [CURR_W-1:0] cur, prev, best_curr;
  logic [DUTY_W-1:0] best_l, l_stepped;
  logic [REV_W-1:0]  rev_cnt, rev_eval;
  logic dir, dir_eval, first, hit_bound, clamp_up, best_upd, eval_stop;

  assign clamp_up = (state == ST_HOLD) ? l_up_down : dir;

  duty_clamp #(.L_MIN(L_MIN), .L_MAX(L_MAX), .L_STEP(L_STEP)) u_clamp (
    .l_in     (l),
    .up       (clamp_up),
    .l_out    (l_stepped),
    .hit_bound(hit_bound)
  );

  // An equal reading counts as a reversal so a flat plateau still converges.
  always_comb begin
    dir_eval = dir;
    rev_eval = rev_cnt;
    if (!first) begin
      if (cur > prev) begin
        rev_eval = '0;
      end else begin
        dir_eval = ~dir;
        rev_eval = rev_cnt + 1'b1;
      end
    end
  end

  assign best_upd  = first || (cur > best_curr);
  assign eval_stop = !first && (rev_eval >= REV_MAX);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (!swipt_alive) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (start) state_next = ST_SETTLE;
        ST_SETTLE: if (settle_cnt == '0) state_next = ST_MEAS;
        ST_MEAS:   if (mean_valid) state_next = ST_EVAL;
        ST_EVAL:   state_next = eval_stop ? ST_HOLD : ST_STEP;
        ST_STEP:   state_next = ST_SETTLE;
        ST_HOLD:   if (start) state_next = ST_SETTLE;
        default:   state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    measure = (state == ST_MEAS);
    busy    = (state != ST_IDLE) && (state != ST_HOLD);
    done    = (state == ST_HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      l          <= L_RESET;
      dir        <= 1'b1;
      rev_cnt    <= '0;
      best_curr  <= '0;
      best_l     <= L_RESET;
      prev       <= '0;
      cur        <= '0;
      first      <= 1'b1;
      settle_cnt <= '0;
    end else if (!swipt_alive) begin
      l          <= L_RESET;
      settle_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_HOLD: begin
          if (start) begin
            dir        <= 1'b1;
            best_curr  <= '0;
            rev_cnt    <= '0;
            first      <= 1'b1;
            settle_cnt <= SETTLE_LOAD;
          end else if (state == ST_HOLD && l_rdy) begin
            l <= l_stepped;
          end
        end
        ST_SETTLE: if (settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;
        ST_MEAS:   if (mean_valid) cur <= mean_curr;
        ST_EVAL: begin
          dir     <= dir_eval;
          rev_cnt <= rev_eval;
          prev    <= cur;
          first   <= 1'b0;
          if (best_upd) begin
            best_curr <= cur;
            best_l    <= l;
          end
          if (eval_stop) l <= best_upd ? l : best_l;
        end
        ST_STEP: begin
          l          <= l_stepped;
          settle_cnt <= SETTLE_LOAD;
          if (hit_bound) begin
            dir     <= ~dir;
            rev_cnt <= rev_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_duty_optimizer.sv
// Directed and randomised checks of duty_optimizer against a behavioural hill-climb model.
module tb_duty_optimizer;
  localparam int L_INIT     = 200;
  localparam int L_MIN      = 20;
  localparam int L_MAX      = 400;
  localparam int L_STEP     = 10;
  localparam int SETTLE_CYC = 1000;
  localparam int REV_LIMIT  = 4;

  logic        clk = 1'b0;
  logic        rst, swipt_alive, start, mean_valid, l_rdy, l_up_down;
  logic [11:0] mean_curr, l;
  logic        measure, busy, done;

  int n_assert = 0;
  int n_fail   = 0;

  int m_l, m_dir, m_best_c, m_best_l, m_prev, m_rev;
  bit m_first;

  duty_optimizer dut (
    .clk        (clk),
    .rst        (rst),
    .swipt_alive(swipt_alive),
    .start      (start),
    .mean_curr  (mean_curr),
    .mean_valid (mean_valid),
    .l_rdy      (l_rdy),
    .l_up_down  (l_up_down),
    .l          (l),
    .measure    (measure),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_start();
    m_dir    = 1;
    m_best_c = 0;
    m_rev    = 0;
    m_first  = 1'b1;
  endtask

  task automatic model_nudge(input bit up);
    if (up) m_l = (m_l + L_STEP > L_MAX) ? L_MAX : m_l + L_STEP;
    else    m_l = (m_l - L_STEP < L_MIN) ? L_MIN : m_l - L_STEP;
  endtask

  // Climb rules: higher current keeps direction, anything else reverses; landing on a limit also reverses.
  task automatic model_meas(input int v, output bit hold);
    int t;
    hold = 1'b0;
    if (m_first) begin
      m_best_c = v;
      m_best_l = m_l;
      m_prev   = v;
      m_first  = 1'b0;
    end else begin
      if (v > m_prev) m_rev = 0;
      else begin
        m_dir = -m_dir;
        m_rev++;
      end
      if (v > m_best_c) begin
        m_best_c = v;
        m_best_l = m_l;
      end
      m_prev = v;
      hold   = (m_rev >= REV_LIMIT);
    end
    if (hold) begin
      m_l = m_best_l;
    end else begin
      t = m_l + m_dir * L_STEP;
      if (t >= L_MAX || t <= L_MIN) begin
        t     = (t >= L_MAX) ? L_MAX : L_MIN;
        m_dir = -m_dir;
        m_rev++;
      end
      m_l = t;
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    model_start();
  endtask

  // Called at SETTLE entry (or exp_dwell cycles before MEAS); leaves the DUT in SETTLE or HOLD.
  task automatic run_meas(input int v, input int exp_dwell, output bit hold);
    int n;
    n = 0;
    while (measure !== 1'b1 && n < 3000) begin
      tick();
      n++;
    end
    check("settle_dwell", n, exp_dwell);
    mean_curr  = 12'(v);
    mean_valid = 1'b1;
    tick();
    mean_valid = 1'b0;
    check("measure_drop", measure, 0);
    model_meas(v, hold);
    tick();
    if (hold) begin
      check("hold_done", done, 1);
      check("hold_busy", busy, 0);
      check("hold_l", l, m_l);
    end else begin
      tick();
      check("step_l", l, m_l);
      check("l_in_range", (l >= L_MIN) && (l <= L_MAX), 1);
    end
  endtask

  initial begin
    bit hold;
    bit saw_max;
    int tie_l, n;
    int a_vals[7] = '{100, 110, 120, 115, 105, 100, 95};
    int t_vals[5] = '{150, 150, 100, 90, 80};

    rst = 1'b1; swipt_alive = 1'b1; start = 1'b0; mean_valid = 1'b0;
    l_rdy = 1'b0; l_up_down = 1'b0; mean_curr = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("reset_l", l, L_INIT);
    check("reset_measure", measure, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    m_l = L_INIT;

    l_rdy = 1'b1; l_up_down = 1'b1;
    tick();
    l_rdy = 1'b0;
    tick();
    check("idle_l_rdy_ignored", l, L_INIT);

    // Rising then falling current until convergence.
    do_start();
    check("start_busy", busy, 1);
    foreach (a_vals[i]) begin
      run_meas(a_vals[i], SETTLE_CYC, hold);
      if (hold) break;
    end
    check("a_done", done, 1);

    l_up_down = 1'b0; l_rdy = 1'b1;
    tick();
    l_rdy = 1'b0;
    model_nudge(1'b0);
    check("hold_nudge_down", l, m_l);
    l_up_down = 1'b1; l_rdy = 1'b1;
    tick();
    l_rdy = 1'b0;
    model_nudge(1'b1);
    check("hold_nudge_up", l, m_l);

    // l_rdy and a second start while settling must both be ignored.
    do_start();
    l_rdy = 1'b1; l_up_down = 1'b1;
    tick();
    l_rdy = 1'b0;
    check("settle_l_rdy_ignored", l, m_l);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_start_busy", busy, 1);
    tie_l = m_l;
    foreach (t_vals[i]) begin
      run_meas(t_vals[i], (i == 0) ? SETTLE_CYC - 2 : SETTLE_CYC, hold);
      if (hold) break;
    end
    check("tie_done", done, 1);
    check("tie_best_l", l, tie_l);

    // Steady climb into the upper bound.
    do_start();
    saw_max = 1'b0;
    for (int k = 0; k < 21; k++) begin
      run_meas(500 + 10 * k, SETTLE_CYC, hold);
      if (l == 12'(L_MAX)) saw_max = 1'b1;
      if (hold) break;
    end
    check("clamp_reached_max", saw_max, 1);

    // Link loss in MEAS, then a stray strobe.
    n = 0;
    while (measure !== 1'b1 && n < 3000) begin
      tick();
      n++;
    end
    check("abort_in_meas", measure, 1);
    swipt_alive = 1'b0;
    tick();
    swipt_alive = 1'b1;
    m_l = L_INIT;
    check("abort_measure", measure, 0);
    check("abort_busy", busy, 0);
    check("abort_l", l, L_INIT);
    mean_curr = 12'd123; mean_valid = 1'b1;
    tick();
    mean_valid = 1'b0;
    check("stray_valid_busy", busy, 0);
    check("stray_valid_measure", measure, 0);
    tick();
    check("stray_valid_done", done, 0);

    // Reset mid-SETTLE, then a clean restart.
    do_start();
    repeat (500) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_l = L_INIT;
    check("rst_settle_l", l, L_INIT);
    check("rst_settle_busy", busy, 0);
    check("rst_settle_measure", measure, 0);
    check("rst_settle_done", done, 0);
    do_start();
    run_meas(300, SETTLE_CYC, hold);

    for (int r = 0; r < 2; r++) begin
      swipt_alive = 1'b0;
      tick();
      swipt_alive = 1'b1;
      m_l = L_INIT;
      check("rand_abort_l", l, L_INIT);
      do_start();
      hold = 1'b0;
      for (int k = 0; k < 12 && !hold; k++)
        run_meas(int'($urandom_range(0, 4095)), SETTLE_CYC, hold);
      if (hold) begin
        for (int j = 0; j < 6; j++) begin
          l_up_down = 1'($urandom_range(0, 1));
          l_rdy = 1'b1;
          tick();
          l_rdy = 1'b0;
          model_nudge(l_up_down);
          check("rand_nudge_l", l, m_l);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
